// File: rtl/pipes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pipes_pkg                                                      |
// | Purpose   : Types and constants shared by the pipeline blocks: the operand |
// |             select encodings, the operand-issue entry struct and the       |
// |             default number of bypass channels.                             |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package pipes_pkg;

   // Default number of bypass channels into operand issue.
   localparam int NBYP_DEFAULT = 2;

   // Widest datapath an operand_issue entry can hold. Narrower XLEN
   // instances keep their data in the low bits.
   localparam int OI_XLEN_MAX = 64;

   typedef enum logic [1:0] {
      OPA_REG  = 2'd0,
      OPA_PC   = 2'd1,
      OPA_ZERO = 2'd2
   } opa_sel_t;

   typedef enum logic [1:0] {
      OPB_REG  = 2'd0,
      OPB_IMM  = 2'd1,
      OPB_FOUR = 2'd2
   } opb_sel_t;

   typedef struct packed {
      logic [OI_XLEN_MAX-1:0] srca;
      logic [OI_XLEN_MAX-1:0] srcb;
      logic [OI_XLEN_MAX-1:0] stdata;
   } oi_entry_t;

endpackage
`default_nettype wire

// File: rtl/bypass_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bypass_sel                                                     |
// | Purpose   : Combinational per-operand forwarding. Picks the result of the  |
// |             youngest (lowest-numbered) valid bypass channel whose          |
// |             destination matches the source index; x0 is never forwarded.   |
// | Macro     : OPERAND_BYPASS_EN - when undefined the bypass inputs are       |
// |             ignored and the register-file value passes straight through.  |
// | Ports     : idx        in  5           source register index               |
// |             rf_data    in  XLEN        register-file read data             |
// |             byp_valid  in  NBYP        bypass channel valid                |
// |             byp_rd     in  NBYP x 5    bypass destination index            |
// |             byp_data   in  NBYP x XLEN bypass result                       |
// |             fwd_data   out XLEN        forwarded operand value             |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module bypass_sel #(
   parameter int XLEN = 64,
   parameter int NBYP = 2
) (
   input  logic [4:0]                idx,
   input  logic [XLEN-1:0]           rf_data,
   input  logic [NBYP-1:0]           byp_valid,
   input  logic [NBYP-1:0][4:0]      byp_rd,
   input  logic [NBYP-1:0][XLEN-1:0] byp_data,
   output logic [XLEN-1:0]           fwd_data
);

`ifdef OPERAND_BYPASS_EN
   logic hit;

   // Channels are scanned from youngest to oldest; the first match wins.
   always_comb begin
      fwd_data = rf_data;
      hit      = 1'b0;
      for (int i = 0; i < NBYP; i++) begin
         if (!hit && (idx != 5'd0) && byp_valid[i] && (byp_rd[i] == idx)) begin
            fwd_data = byp_data[i];
            hit      = 1'b1;
         end
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{idx, byp_valid, byp_rd, byp_data};
   assign fwd_data   = rf_data;
`endif

endmodule
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : operand_issue                                                  |
// | Purpose   : Forwards rs1/rs2, selects ALU operands A/B and store data in   |
// |             the accept cycle, and registers them into a two-entry          |
// |             (output + skid) buffer. One cycle of latency; in_ready depends |
// |             only on registered state.                                      |
// | Macro     : OPERAND_BYPASS_EN - enables forwarding from the byp_* ports.   |
// | Ports     : clk, reset (async, active-low), flush                          |
// |             in_valid/in_ready, in_pc, in_rs1, in_rs2, in_r1, in_r2,        |
// |             in_imm, in_sela, in_selb          - upstream instruction       |
// |             byp_valid, byp_rd, byp_data       - bypass channels (0 = young)|
// |             out_valid/out_ready, out_srca, out_srcb, out_stdata - operands |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module operand_issue
   import pipes_pkg::*;
#(
   parameter int XLEN = 64,              // must not exceed OI_XLEN_MAX
   parameter int NBYP = NBYP_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [XLEN-1:0]           in_pc,
   input  logic [4:0]                in_rs1,
   input  logic [4:0]                in_rs2,
   input  logic [XLEN-1:0]           in_r1,
   input  logic [XLEN-1:0]           in_r2,
   input  logic [XLEN-1:0]           in_imm,
   input  opa_sel_t                  in_sela,
   input  opb_sel_t                  in_selb,
   input  logic [NBYP-1:0]           byp_valid,
   input  logic [NBYP-1:0][4:0]      byp_rd,
   input  logic [NBYP-1:0][XLEN-1:0] byp_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_srca,
   output logic [XLEN-1:0]           out_srcb,
   output logic [XLEN-1:0]           out_stdata
);

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   oi_entry_t       new_entry;
   logic            accept;

   logic      out_valid_q,  out_valid_d;
   logic      skid_valid_q, skid_valid_d;
   oi_entry_t out_entry_q,  out_entry_d;
   oi_entry_t skid_entry_q, skid_entry_d;

   bypass_sel #(.XLEN(XLEN), .NBYP(NBYP)) u_byp_rs1 (
      .idx       (in_rs1),
      .rf_data   (in_r1),
      .byp_valid (byp_valid),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .fwd_data  (rs1_fwd)
   );

   bypass_sel #(.XLEN(XLEN), .NBYP(NBYP)) u_byp_rs2 (
      .idx       (in_rs2),
      .rf_data   (in_r2),
      .byp_valid (byp_valid),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .fwd_data  (rs2_fwd)
   );

   // Operand selection for the instruction presented this cycle.
   always_comb begin
      new_entry        = '0;
      new_entry.stdata = OI_XLEN_MAX'(rs2_fwd);
      case (in_sela)
         OPA_REG: new_entry.srca = OI_XLEN_MAX'(rs1_fwd);
         OPA_PC:  new_entry.srca = OI_XLEN_MAX'(in_pc);
         default: new_entry.srca = '0;
      endcase
      case (in_selb)
         OPB_REG:  new_entry.srcb = OI_XLEN_MAX'(rs2_fwd);
         OPB_IMM:  new_entry.srcb = OI_XLEN_MAX'(in_imm);
         OPB_FOUR: new_entry.srcb = OI_XLEN_MAX'(4);
         default:  new_entry.srcb = '0;
      endcase
   end

   // Ready only while the skid slot is free, so the upstream never sees
   // out_ready combinationally.
   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_entry_d  = out_entry_q;
      skid_valid_d = skid_valid_q;
      skid_entry_d = skid_entry_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         out_entry_d  = '0;
         skid_valid_d = 1'b0;
         skid_entry_d = '0;
      end else if (!out_valid_q || out_ready) begin
         // Output slot drains (or is empty): older skid entry first. When the
         // skid slot is full, accept is low, so no entry can be lost here.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_entry_d  = skid_entry_q;
            skid_valid_d = 1'b0;
            skid_entry_d = '0;
         end else if (accept) begin
            out_valid_d  = 1'b1;
            out_entry_d  = new_entry;
         end else begin
            out_valid_d  = 1'b0;
            out_entry_d  = '0;
         end
      end else if (accept) begin
         // Output stalled: park the new entry behind it.
         skid_valid_d = 1'b1;
         skid_entry_d = new_entry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_entry_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_entry_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_entry_q  <= out_entry_d;
         skid_valid_q <= skid_valid_d;
         skid_entry_q <= skid_entry_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_srca   = out_valid_q ? out_entry_q.srca[XLEN-1:0]   : '0;
   assign out_srcb   = out_valid_q ? out_entry_q.srcb[XLEN-1:0]   : '0;
   assign out_stdata = out_valid_q ? out_entry_q.stdata[XLEN-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_operand_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_operand_issue                                               |
// | Purpose   : Self-checking bench for operand_issue: directed scenarios plus |
// |             randomized traffic against a queue-based reference model.     |
// | Macro     : OPERAND_BYPASS_EN - expected values follow the same macro.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_operand_issue;
   import pipes_pkg::*;

   localparam int XLEN = 64;
   localparam int NBYP = 2;

   logic                      clk;
   logic                      reset;
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [XLEN-1:0]           in_pc;
   logic [4:0]                in_rs1;
   logic [4:0]                in_rs2;
   logic [XLEN-1:0]           in_r1;
   logic [XLEN-1:0]           in_r2;
   logic [XLEN-1:0]           in_imm;
   opa_sel_t                  in_sela;
   opb_sel_t                  in_selb;
   logic [NBYP-1:0]           byp_valid;
   logic [NBYP-1:0][4:0]      byp_rd;
   logic [NBYP-1:0][XLEN-1:0] byp_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [XLEN-1:0]           out_srca;
   logic [XLEN-1:0]           out_srcb;
   logic [XLEN-1:0]           out_stdata;

   operand_issue #(.XLEN(XLEN), .NBYP(NBYP)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_r1      (in_r1),
      .in_r2      (in_r2),
      .in_imm     (in_imm),
      .in_sela    (in_sela),
      .in_selb    (in_selb),
      .byp_valid  (byp_valid),
      .byp_rd     (byp_rd),
      .byp_data   (byp_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_srca   (out_srca),
      .out_srcb   (out_srcb),
      .out_stdata (out_stdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ordered list of held entries, head = presented entry.
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] s;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] rf);
      logic [63:0] v;
      logic        found;
      v     = rf;
      found = 1'b0;
`ifdef OPERAND_BYPASS_EN
      if (idx != 5'd0) begin
         for (int i = 0; i < NBYP; i++) begin
            if (!found && byp_valid[i] && byp_rd[i] == idx) begin
               v     = byp_data[i];
               found = 1'b1;
            end
         end
      end
`endif
      return v;
   endfunction

   function automatic ent_t model_entry();
      ent_t e;
      e.s = fwd(in_rs2, in_r2);
      case (in_sela)
         OPA_REG: e.a = fwd(in_rs1, in_r1);
         OPA_PC:  e.a = in_pc;
         default: e.a = 64'd0;
      endcase
      case (in_selb)
         OPB_REG:  e.b = e.s;
         OPB_IMM:  e.b = in_imm;
         default:  e.b = 64'd4;
      endcase
      return e;
   endfunction

   task automatic check_outputs();
      ent_t h;
      h = '{64'd0, 64'd0, 64'd0};
      if (q.size() > 0) h = q[0];
      chk("out_valid",  {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready",   {63'd0, in_ready},  {63'd0, q.size() < 2});
      chk("out_srca",   out_srca,   h.a);
      chk("out_srcb",   out_srcb,   h.b);
      chk("out_stdata", out_stdata, h.s);
   endtask

   // Called at a falling edge with inputs already driven: advance the model
   // by one clock, then compare at the next falling edge.
   task automatic cycle();
      ent_t e;
      bit   push;
      bit   pop;
      int   n;
      n    = q.size();
      e    = model_entry();
      push = in_valid && !flush && n < 2;
      pop  = !flush && n > 0 && out_ready;
      if (flush) q.delete();
      else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_r1     = '0;
      in_r2     = '0;
      in_imm    = '0;
      in_sela   = OPA_REG;
      in_selb   = OPB_REG;
      byp_valid = '0;
      byp_rd    = '0;
      byp_data  = '0;
      out_ready = 1'b1;
   endtask

   logic [63:0] exp_a;

   initial begin
      idle_inputs();
      reset = 1'b0;
      #2;
      check_outputs();
      repeat (2) @(negedge clk);
      check_outputs();
      reset = 1'b1;

      // Bypass priority: channel 0 wins over channel 1.
      in_valid = 1'b1; in_rs1 = 5'd5; in_r1 = 64'h11; in_sela = OPA_REG;
      byp_valid = 2'b11; byp_rd[0] = 5'd5; byp_rd[1] = 5'd5;
      byp_data[0] = 64'hAA; byp_data[1] = 64'hBB;
      cycle();
`ifdef OPERAND_BYPASS_EN
      exp_a = 64'hAA;
`else
      exp_a = 64'h11;
`endif
      chk("byp_prio_srca", out_srca, exp_a);
      idle_inputs();

      // x0 is never forwarded.
      in_valid = 1'b1; in_rs2 = 5'd0; in_r2 = 64'd0; in_selb = OPB_REG;
      byp_valid = 2'b01; byp_rd[0] = 5'd0; byp_data[0] = 64'hFF;
      cycle();
      chk("x0_srcb", out_srcb, 64'd0);
      chk("x0_stdata", out_stdata, 64'd0);
      idle_inputs();

      // Select modes.
      in_valid = 1'b1; in_pc = 64'h8000_0000; in_imm = 64'h10;
      in_rs2 = 5'd3; in_r2 = 64'h33;
      in_sela = OPA_PC; in_selb = OPB_FOUR;
      cycle();
      chk("sel_pc_srca", out_srca, 64'h8000_0000);
      chk("sel_four_srcb", out_srcb, 64'd4);
      in_sela = OPA_ZERO; in_selb = OPB_IMM;
      cycle();
      chk("sel_zero_srca", out_srca, 64'd0);
      chk("sel_imm_srcb", out_srcb, 64'h10);
      chk("sel_stdata", out_stdata, 64'h33);
      idle_inputs();
      cycle();

      // Backpressure: A held, B skids, C waits for space.
      out_ready = 1'b0; in_valid = 1'b1; in_sela = OPA_PC;
      in_pc = 64'hA00; cycle();
      in_pc = 64'hB00; cycle();
      in_pc = 64'hC00; cycle();
      chk("bp_hold_a", out_srca, 64'hA00);
      chk("bp_full", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1; cycle();
      chk("bp_b", out_srca, 64'hB00);
      cycle();
      chk("bp_c", out_srca, 64'hC00);
      in_valid = 1'b0; cycle();
      chk("bp_drained", {63'd0, out_valid}, 64'd0);
      idle_inputs();

      // Flush with two held entries and a competing input.
      out_ready = 1'b0; in_valid = 1'b1; in_sela = OPA_PC;
      in_pc = 64'h1; cycle();
      in_pc = 64'h2; cycle();
      flush = 1'b1; in_pc = 64'h3; cycle();
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);
      flush = 1'b0; in_valid = 1'b0; cycle();
      chk("flush_discard", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset mid-stream.
      in_valid = 1'b1; in_pc = 64'h44; cycle();
      #2 reset = 1'b0;
      #1;
      q.delete();
      chk("rst_async_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_async_srca", out_srca, 64'd0);
      chk("rst_async_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      cycle();

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_pc     = {$urandom, $urandom};
         in_rs1    = 5'($urandom_range(0, 7));
         in_rs2    = 5'($urandom_range(0, 7));
         in_r1     = {$urandom, $urandom};
         in_r2     = {$urandom, $urandom};
         in_imm    = {$urandom, $urandom};
         in_sela   = opa_sel_t'($urandom_range(0, 2));
         in_selb   = opb_sel_t'($urandom_range(0, 2));
         for (int c = 0; c < NBYP; c++) begin
            byp_valid[c] = 1'($urandom_range(0, 1));
            byp_rd[c]    = 5'($urandom_range(0, 7));
            byp_data[c]  = {$urandom, $urandom};
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
